// File: rtl/memwb_stage_skid.sv
// MEM/WB pipeline stage with valid/ready handshake and a two-entry skid buffer.
//
// Carries writeback control (wb, load), the ALU result, memory read data and the
// destination register from the memory stage to register-file writeback.
// Also provides the writeback data mux, the effective write enable and
// forwarding-hit flags for two source operands.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of every buffered entry
//   in_valid/in_ready   upstream handshake; in_ready depends only on registered state
//   in_wb, in_load,
//   in_result, in_resm,
//   in_rd               incoming payload
//   out_valid/out_ready downstream handshake; the head entry is consumed on a pop
//   out_*               head-entry payload; all zero while the head is invalid
//   wb_data, wb_en      writeback data mux and effective register-file write enable
//   fwd_rs, fwd_rt      source registers from the hazard unit
//   fwd_rs_hit/_rt_hit  head entry writes the corresponding source register
//   occupancy           number of entries held (0..2)
module memwb_stage_skid #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RA_W     = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb,
  input  logic              in_load,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_resm,
  input  logic [RA_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb,
  output logic              out_load,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_resm,
  output logic [RA_W-1:0]   out_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  input  logic [RA_W-1:0]   fwd_rs,
  input  logic [RA_W-1:0]   fwd_rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              wb;
    logic              load;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] resm;
    logic [RA_W-1:0]   rd;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic accept;
  logic pop;
  logic rd_is_zero;

  assign in_entry = '{wb: in_wb, load: in_load, result: in_result, resm: in_resm, rd: in_rd};

  // Both handshakes are derived from registered state only.
  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over a same-cycle accept; a same-cycle pop is simply consumed.
      state_d = StEmpty;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = StTwo;
          end else if (pop) begin
            // Keep an invalid head's payload at zero.
            head_d  = '0;
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            head_d  = skid_q;
            skid_d  = '0;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_wb     = head_q.wb;
  assign out_load   = head_q.load;
  assign out_result = head_q.result;
  assign out_resm   = head_q.resm;
  assign out_rd     = head_q.rd;

  assign wb_data    = head_q.load ? head_q.resm : head_q.result;
  assign rd_is_zero = (head_q.rd == '0);
  assign wb_en      = out_valid & head_q.wb & ~(ZERO_REG & rd_is_zero);

  // Only the head is visible to forwarding; the skid entry is not yet ahead of it.
  assign fwd_rs_hit = wb_en & (head_q.rd == fwd_rs);
  assign fwd_rt_hit = wb_en & (head_q.rd == fwd_rt);

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
